// File: rtl/sram_template_param.sv
// Set-associative SRAM template: one single-port array, power-up zero sweep, 1-cycle read latency.
// Define SRAM_TEMPLATE_HOLD_READ_EN to keep io_r_data at the last response between reads.
module sram_template_param #(
    parameter int DATA_W = 20,
    parameter int WAYS   = 4,
    parameter int SETS   = 128,
    localparam int ADDR_W = $clog2(SETS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_r_req_valid,
    output logic                     io_r_req_ready,
    input  logic [ADDR_W-1:0]        io_r_addr,
    output logic                     io_r_resp_valid,
    output logic [WAYS*DATA_W-1:0]   io_r_data,
    input  logic                     io_w_en,
    output logic                     io_w_ready,
    input  logic [ADDR_W-1:0]        io_w_addr,
    input  logic [WAYS*DATA_W-1:0]   io_w_data,
    input  logic [WAYS-1:0]          io_w_mask
);
    typedef enum logic {INIT, IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(SETS - 1);

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             cnt_q, cnt_d;
    logic                          resp_valid_q, resp_valid_d;
    logic [WAYS-1:0][DATA_W-1:0]   r_data_q, r_data_d;
    logic [WAYS-1:0][DATA_W-1:0]   mem_q [SETS];

    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [WAYS-1:0]               mem_wmask;
    logic [WAYS-1:0][DATA_W-1:0]   mem_wdata;
    logic                          w_fire, r_fire;

    assign io_w_ready      = (state_q == IDLE);
    assign io_r_req_ready  = (state_q == IDLE) && !io_w_en;
    assign w_fire          = io_w_en && io_w_ready;
    assign r_fire          = io_r_req_valid && io_r_req_ready;
    assign io_r_resp_valid = resp_valid_q;
    assign io_r_data       = r_data_q;

    // One shared port: the sweep, a write, or a read owns mem_addr each cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_we       = 1'b0;
        mem_addr     = io_r_addr;
        mem_wmask    = '0;
        mem_wdata    = '0;
        resp_valid_d = r_fire;
`ifdef SRAM_TEMPLATE_HOLD_READ_EN
        r_data_d     = r_data_q;
`else
        r_data_d     = '0;
`endif
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wmask = '1;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_SET) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (w_fire) begin
                    mem_we    = 1'b1;
                    mem_addr  = io_w_addr;
                    mem_wmask = io_w_mask;
                    mem_wdata = io_w_data;
                end
            end
            default: state_d = INIT;
        endcase
        if (r_fire) r_data_d = mem_q[mem_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            r_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            r_data_q     <= r_data_d;
        end
    end

    // Array is not reset; the INIT sweep clears it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int k = 0; k < WAYS; k++) begin
                if (mem_wmask[k]) mem_q[mem_addr][k] <= mem_wdata[k];
            end
        end
    end
endmodule

// File: tb/tb_sram_template_param.sv
// Bench for sram_template_param: vector table of write/read-back pairs plus handshake and reset sequences.
module tb_sram_template_param;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_r_req_valid;
    logic        io_r_req_ready;
    logic [6:0]  io_r_addr;
    logic        io_r_resp_valid;
    logic [79:0] io_r_data;
    logic        io_w_en;
    logic        io_w_ready;
    logic [6:0]  io_w_addr;
    logic [79:0] io_w_data;
    logic [3:0]  io_w_mask;

    sram_template_param dut (
        .clock(clock), .reset(reset),
        .io_r_req_valid(io_r_req_valid), .io_r_req_ready(io_r_req_ready),
        .io_r_addr(io_r_addr), .io_r_resp_valid(io_r_resp_valid), .io_r_data(io_r_data),
        .io_w_en(io_w_en), .io_w_ready(io_w_ready), .io_w_addr(io_w_addr),
        .io_w_data(io_w_data), .io_w_mask(io_w_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  addr;
        logic [79:0] data;
        logic [3:0]  mask;
        logic [79:0] exp;
    } vec_t;

    vec_t        tbl [6];
    logic [79:0] sb [$];
    int          nvec = 0;
    int          nerr = 0;
    logic [79:0] a5, a0, idle_exp;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every response must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (io_r_resp_valid) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_resp: got data %h want no response", io_r_data);
            end else begin
                logic [79:0] e;
                e = sb.pop_front();
                if (io_r_data !== e) begin
                    nerr++;
                    $display("FAIL resp_data: got %h want %h", io_r_data, e);
                end
            end
        end
    end

    // Called just after reset release; counts cycles with io_w_ready low.
    task automatic wait_init();
        int   n = 0;
        logic rdy_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (io_w_ready) break;
            rdy_seen |= io_r_req_ready;
            n++;
        end
        chk("init_len", 80'(n), 80'd128);
        chk("init_r_ready_low", 80'(rdy_seen), 80'd0);
    endtask

    task automatic rd(input logic [6:0] addr, input logic [79:0] exp);
        @(posedge clock); #1;
        io_r_req_valid = 1'b1;
        io_r_addr      = addr;
        sb.push_back(exp);
        @(posedge clock); #1;
        io_r_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{7'd5,   {20'h44444, 20'h33333, 20'h22222, 20'h11111}, 4'hF,
                           {20'h44444, 20'h33333, 20'h22222, 20'h11111}};
        tbl[1] = '{7'd5,   {20'hFFFFF, 20'hABCDE, 20'hFFFFF, 20'hFFFFF}, 4'h4,
                           {20'h44444, 20'hABCDE, 20'h22222, 20'h11111}};
        tbl[2] = '{7'd127, {20'h00004, 20'h00003, 20'h00002, 20'h00001}, 4'hF,
                           {20'h00004, 20'h00003, 20'h00002, 20'h00001}};
        tbl[3] = '{7'd127, {80{1'b1}}, 4'h0,
                           {20'h00004, 20'h00003, 20'h00002, 20'h00001}};
        tbl[4] = '{7'd0,   {20'hAAAAA, 20'hBBBBB, 20'hCCCCC, 20'hDDDDD}, 4'h9,
                           {20'hAAAAA, 20'h00000, 20'h00000, 20'hDDDDD}};
        tbl[5] = '{7'd64,  {80{1'b1}}, 4'h0, 80'd0};
        a5 = tbl[1].exp;
        a0 = tbl[4].exp;

        reset = 1'b1;
        io_r_req_valid = 1'b0; io_r_addr = '0;
        io_w_en = 1'b0; io_w_addr = '0; io_w_data = '0; io_w_mask = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_w_ready", 80'(io_w_ready), 80'd0);
        chk("rst_r_ready", 80'(io_r_req_ready), 80'd0);
        chk("rst_resp_valid", 80'(io_r_resp_valid), 80'd0);
        chk("rst_r_data", io_r_data, 80'd0);

        // Requests during INIT must be ignored, not queued.
        io_w_en = 1'b1; io_w_addr = 7'd3; io_w_data = {80{1'b1}}; io_w_mask = 4'hF;
        io_r_req_valid = 1'b1; io_r_addr = 7'd3;
        @(posedge clock); #1;
        reset = 1'b0;
        wait_init();
        io_w_en = 1'b0; io_r_req_valid = 1'b0;
        rd(7'd3, 80'd0);
        rd(7'd100, 80'd0);

        // Write in cycle N, read the same set in cycle N+1.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            io_w_en = 1'b1; io_w_addr = tbl[i].addr; io_w_data = tbl[i].data; io_w_mask = tbl[i].mask;
            @(posedge clock); #1;
            io_w_en = 1'b0;
            io_r_req_valid = 1'b1; io_r_addr = tbl[i].addr;
            sb.push_back(tbl[i].exp);
            @(posedge clock); #1;
            io_r_req_valid = 1'b0;
        end
        repeat (2) @(posedge clock);

        // Write/read conflict: read refused for 3 cycles, accepted once io_w_en drops.
        #1;
        io_w_en = 1'b1; io_w_addr = 7'd5; io_w_data = {80{1'b1}}; io_w_mask = 4'h0;
        io_r_req_valid = 1'b1; io_r_addr = 7'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("conflict_r_ready", 80'(io_r_req_ready), 80'd0);
            @(posedge clock); #1;
        end
        io_w_en = 1'b0;
        sb.push_back(a5);
        @(negedge clock);
        chk("retry_r_ready", 80'(io_r_req_ready), 80'd1);
        @(posedge clock); #1;
        io_r_req_valid = 1'b0;
        repeat (2) @(posedge clock);

        // Idle cycles between two reads.
`ifdef SRAM_TEMPLATE_HOLD_READ_EN
        idle_exp = a5;
`else
        idle_exp = 80'd0;
`endif
        rd(7'd5, a5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("idle_resp_valid", 80'(io_r_resp_valid), 80'd0);
            chk("idle_r_data", io_r_data, idle_exp);
        end
        rd(7'd0, a0);
        repeat (2) @(posedge clock);

        // Reset while a response is on the outputs: it must vanish at once.
        #1;
        io_r_req_valid = 1'b1; io_r_addr = 7'd5;
        @(posedge clock); #2;
        reset = 1'b1;
        io_r_req_valid = 1'b0;
        #1;
        chk("rst_async_resp_valid", 80'(io_r_resp_valid), 80'd0);
        chk("rst_async_r_data", io_r_data, 80'd0);
        chk("rst_async_w_ready", 80'(io_w_ready), 80'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Reset in the middle of the sweep restarts it from set 0.
        repeat (60) @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        wait_init();
        rd(7'd5, 80'd0);
        rd(7'd127, 80'd0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("sb_drained", 80'(sb.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sram_template_param.md
SRAM_TEMPLATE_PARAM -- requirements
Module: sram_template_param

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_W, 20, bits per way.
- WAYS, 4, ways per set; one write-mask bit per way.
- SETS, 128, number of sets; must be 2..1024.
- ADDR_W, clog2(SETS), derived address width; never overridden.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_r_req_valid  in  1  read request.
- io_r_req_ready  out  1  read request accepted this cycle.
- io_r_addr  in  ADDR_W  read set index.
- io_r_resp_valid  out  1  io_r_data valid this cycle.
- io_r_data  out  WAYS*DATA_W  read data; way k occupies bits [k*DATA_W +: DATA_W].
- io_w_en  in  1  write request.
- io_w_ready  out  1  write accepted this cycle.
- io_w_addr  in  ADDR_W  write set index.
- io_w_data  in  WAYS*DATA_W  write data, same way layout as io_r_data.
- io_w_mask  in  WAYS  per-way write enable.

Function
REQ-003 Storage SHALL be one single-port array of SETS x WAYS x DATA_W bits, doing at most one access (read or write) per cycle.
REQ-004 The FSM SHALL have two states, INIT and IDLE; reset forces INIT.
REQ-005 In INIT, a set counter starts at 0 and each cycle writes all-zero data to every way of set counter; after set SETS-1 is written, the FSM moves to IDLE.
REQ-006 INIT SHALL therefore last exactly SETS cycles after reset deasserts.
REQ-007 In INIT, io_w_ready=0 and io_r_req_ready=0; user requests are ignored, not queued.
REQ-008 In IDLE, io_w_ready=1.
REQ-009 In IDLE, io_r_req_ready = !io_w_en, so a write takes priority over a read in the same cycle.
REQ-010 A write is accepted when io_w_en && io_w_ready; only ways with io_w_mask[k]=1 are updated; masked-off ways keep their old value.
REQ-011 A write with io_w_mask=0 SHALL be accepted but change no state.
REQ-012 A read is accepted when io_r_req_valid && io_r_req_ready.
REQ-013 Read latency SHALL be 1: io_r_resp_valid=1 and io_r_data = array[io_r_addr] in the cycle after acceptance, for one cycle per accepted read.
REQ-014 Back-to-back accepted reads SHALL give back-to-back responses at full throughput.
REQ-015 A read in cycle N+1 of an address written in cycle N SHALL return the data written in cycle N; there is no stale forwarding window.
REQ-016 A read refused because a write is in the same cycle SHALL produce no response; the requester must hold valid and retry.
REQ-017 io_r_addr and io_w_addr values >= SETS SHALL be treated as address modulo 2^ADDR_W; out-of-range behaviour when SETS is not a power of two is undefined, and the bench shall not drive it.

Reset
REQ-018 Reset SHALL take effect asynchronously: the FSM enters INIT, the counter clears to 0, and io_r_resp_valid, io_r_req_ready and io_w_ready drop to 0 immediately.
REQ-019 io_r_data SHALL reset to 0.
REQ-020 Array contents are not cleared by reset itself; they are cleared by the INIT sweep.
REQ-021 Reset asserted mid-INIT SHALL restart the sweep from set 0.
REQ-022 Reset asserted in IDLE SHALL abandon any in-flight read response.

Configuration
REQ-023 Macro SRAM_TEMPLATE_HOLD_READ_EN, when defined: io_r_data SHALL hold the most recent read response until the next response or reset.
REQ-024 Without SRAM_TEMPLATE_HOLD_READ_EN: io_r_data SHALL be 0 in every cycle where io_r_resp_valid=0.
REQ-025 The macro SHALL NOT change handshake timing or latency.

Verification
REQ-026 Reset release with SETS=128 -> ready signals low for exactly 128 cycles, then io_w_ready=1; a read of any set returns 0.
REQ-027 Write addr 5, data way0..3 = 0x11111/0x22222/0x33333/0x44444, mask 0xF; read addr 5 the next cycle -> response one cycle later equals written data, io_r_resp_valid pulses once.
REQ-028 Then write addr 5, mask 0b0100, way2=0xABCDE; read -> ways 0/1/3 unchanged, way2=0xABCDE.
REQ-029 io_r_req_valid and io_w_en both high for 3 cycles -> io_r_req_ready=0 and no responses; the read is accepted in the first cycle io_w_en is low.
REQ-030 Reset asserted at INIT cycle 60 -> on release, the sweep takes a full 128 cycles again; reset asserted with a read in flight -> no response appears.
REQ-031 Two reads, 4 idle cycles apart -> during the idle cycles io_r_data is 0 without the macro, and holds the first read's data with SRAM_TEMPLATE_HOLD_READ_EN defined.
